clock_control: RTL and testbench
================================

CLOCK_CONTROL -- requirements
Module: clock_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a new step-button level.
REQ-002 Parameter COUNT_WIDTH, default 16: width of enable_count.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 clock_div  input  1  divided clock from the clock divider, generated in the clock domain.
REQ-006 run  input  1  run switch; 1 = free-run, 0 = stopped/single-step.
REQ-007 step_btn  input  1  raw, asynchronous, bouncy single-step push-button; 1 = pressed.
REQ-008 halt_req  input  1  halt request from CPU core, level, clock domain.
REQ-009 cpu_en  output  1  one-clock clock-enable pulse to the CPU core.
REQ-010 running  output  1  1 while FSM is in RUNNING.
REQ-011 halted  output  1  1 while FSM is in FAULT_HALT.
REQ-012 enable_count  output  COUNT_WIDTH  number of cpu_en pulses issued since reset.

Function
REQ-013 Tick detect: the block SHALL register clock_div into div_q; tick = clock_div & ~div_q, no extra synchronizer.
REQ-014 Step path: step_btn SHALL pass a 2-flop synchronizer; a debounce counter SHALL update the debounced level only after DEBOUNCE_CYCLES consecutive equal samples differing from it; any differing sample restarts the count.
REQ-015 step_press SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; release SHALL generate nothing.
REQ-016 FSM states: HALTED, RUNNING, STEP_ARMED, FAULT_HALT; encoding free.
REQ-017 HALTED: halt_req=1 -> FAULT_HALT; else run=1 -> RUNNING; else step_press -> STEP_ARMED; else stay.
REQ-018 RUNNING: halt_req=1 -> FAULT_HALT (highest priority); else run=0 -> HALTED; else stay.
REQ-019 STEP_ARMED: halt_req=1 -> FAULT_HALT; else tick -> HALTED; else stay; run and further step_press are ignored while armed.
REQ-020 FAULT_HALT: stay while halt_req=1 or run=1; exit to HALTED only when halt_req=0 and run=0 in the same cycle.
REQ-021 cpu_en SHALL be registered: set to 1 for exactly one cycle after a cycle where tick=1, halt_req=0, and either (state=RUNNING and run=1) or state=STEP_ARMED; else 0.
REQ-022 Latency: clock_div rising sample at edge N -> cpu_en high during cycle N+1.
REQ-023 halt_req=1 coincident with tick SHALL suppress that pulse in every state.
REQ-024 Each step_press SHALL yield exactly one cpu_en pulse (if no halt intervenes); bounces within DEBOUNCE_CYCLES yield none.
REQ-025 enable_count SHALL increment by 1 in the cycle after each cpu_en pulse, modulo 2^COUNT_WIDTH; all-ones wraps to 0 without flag.
REQ-026 running and halted SHALL be registered decodes of the current state.

Reset
REQ-027 reset_n=0 SHALL immediately force state HALTED, cpu_en=0, running=0, halted=0, enable_count=0, div_q=0, synchronizer flops 0, debounced level 0, debounce counter 0.
REQ-028 Reset asserted mid-pulse or mid-debounce SHALL abort it; no pulse after deassertion until a new tick or step_press qualifies.
REQ-029 After release, a clock_div already high SHALL generate a tick in the first clock (div_q=0).

Verification
REQ-030 Divider toggling clock_div every 2 clocks, run=1 from reset: cpu_en one cycle wide every 4 clocks; enable_count=5 after 5 pulses.
REQ-031 run=0, step_btn bounces 1-0-1-0 at 1-cycle spacing then held 1 for 10 cycles: exactly one cpu_en on next tick, state back to HALTED, enable_count=1.
REQ-032 RUNNING, halt_req=1 on the cycle tick=1: no cpu_en, halted=1 next cycle; run=1 with halt_req=0 keeps FAULT_HALT; run=0 -> HALTED.
REQ-033 COUNT_WIDTH=4, run=1, 17 ticks: enable_count reads 15 after 15 pulses, 0 after 16th, 1 after 17th.
REQ-034 reset_n pulsed low asynchronously in STEP_ARMED mid-clock: outputs 0 before next clock edge; no pulse on next tick with run=0.

Source files
------------

// File: rtl/clock_control_if.sv
// -----------------------------------------------------------------------------
// clock_control_if
//
// Bundles the control and status signals of the CPU clock controller.
// The master side is the environment (board, divider, CPU core) and the
// slave side is the clock_control block itself.
//
// Signals
//   clock_div     divided clock from the clock divider, clock domain
//   run           run switch, 1 = free-run, 0 = stopped / single-step
//   step_btn      raw, asynchronous, bouncy single-step button, 1 = pressed
//   halt_req      level halt request from the CPU core, clock domain
//   cpu_en        one-clock clock-enable pulse to the CPU core
//   running       1 while the controller is free-running
//   halted        1 while the controller is in the fault halt state
//   enable_count  number of cpu_en pulses issued since reset (wraps)
// -----------------------------------------------------------------------------
interface clock_control_if #(
  parameter int COUNT_WIDTH = 16
);

  logic                   clock_div;
  logic                   run;
  logic                   step_btn;
  logic                   halt_req;
  logic                   cpu_en;
  logic                   running;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] enable_count;

  // Environment view: drives the controls, observes the status.
  modport master (
    output clock_div,
    output run,
    output step_btn,
    output halt_req,
    input  cpu_en,
    input  running,
    input  halted,
    input  enable_count
  );

  // Controller view: consumes the controls, produces the status.
  modport slave (
    input  clock_div,
    input  run,
    input  step_btn,
    input  halt_req,
    output cpu_en,
    output running,
    output halted,
    output enable_count
  );

endinterface

// File: rtl/clock_control.sv
// -----------------------------------------------------------------------------
// clock_control
//
// Generates single-cycle clock-enable pulses for a CPU core from a divided
// clock. In free-run mode every rising edge of the divided clock produces one
// pulse; in stopped mode a debounced press of the step button arms the
// controller so that exactly one pulse is issued on the next divided-clock
// tick. A halt request from the core suppresses pulses and parks the
// controller in a fault halt state until both the halt request and the run
// switch are released.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a new
//                    step-button level
//   COUNT_WIDTH      width of the enable pulse counter
//
// Ports
//   clock    system clock, all state changes on its rising edge
//   reset_n  asynchronous, active-low reset
//   bus      clock_control_if slave modport (controls in, status out)
// -----------------------------------------------------------------------------
module clock_control #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  clock_control_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HALTED,
    RUNNING,
    STEP_ARMED,
    FAULT_HALT
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic                   div_q;
  logic                   tick;

  logic                   stepMeta_q;
  logic                   stepSync_q;
  logic                   stepLevel_q;
  logic                   stepLevel_d;
  logic [DB_W-1:0]        debounceCnt_q;
  logic [DB_W-1:0]        debounceCnt_d;
  logic                   stepPress_q;
  logic                   stepPress_d;

  logic                   cpuEn_q;
  logic                   cpuEn_d;
  logic                   running_q;
  logic                   running_d;
  logic                   halted_q;
  logic                   halted_d;
  logic [COUNT_WIDTH-1:0] enableCount_q;
  logic [COUNT_WIDTH-1:0] enableCount_d;

  // The divided clock is already in our clock domain, so a single register
  // is enough to find its rising edge. Because div_q resets to 0, a divider
  // output that is already high at reset release counts as a tick on the
  // very first clock.
  assign tick = bus.clock_div & ~div_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 1'b0;
    end else begin
      div_q <= bus.clock_div;
    end
  end

  // The step button is fully asynchronous, so it passes through a two-flop
  // synchronizer before anything else looks at it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stepMeta_q <= 1'b0;
      stepSync_q <= 1'b0;
    end else begin
      stepMeta_q <= bus.step_btn;
      stepSync_q <= stepMeta_q;
    end
  end

  // Debounce: count consecutive synchronized samples that disagree with the
  // accepted level. Any sample that agrees with the accepted level restarts
  // the count, so a bouncing contact never reaches the threshold. On the
  // DEBOUNCE_CYCLES-th disagreeing sample the new level is accepted, and a
  // 0->1 change of the accepted level becomes a one-cycle press strobe.
  always_comb begin
    stepLevel_d   = stepLevel_q;
    debounceCnt_d = '0;
    if (stepSync_q != stepLevel_q) begin
      if (debounceCnt_q == DB_LAST) begin
        stepLevel_d   = stepSync_q;
        debounceCnt_d = '0;
      end else begin
        debounceCnt_d = debounceCnt_q + 1'b1;
      end
    end
    stepPress_d = stepLevel_d & ~stepLevel_q;
  end

  // Debounce state and the registered press strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stepLevel_q   <= 1'b0;
      debounceCnt_q <= '0;
      stepPress_q   <= 1'b0;
    end else begin
      stepLevel_q   <= stepLevel_d;
      debounceCnt_q <= debounceCnt_d;
      stepPress_q   <= stepPress_d;
    end
  end

  // Next-state logic. A halt request always wins. While armed for a single
  // step the run switch and further presses are ignored until the tick that
  // consumes the step. Leaving the fault state needs both halt_req and run
  // low together, so the operator has to drop the run switch deliberately.
  // The enable pulse is decided here from the current state and registered
  // below; a halt request coincident with a tick always suppresses it.
  always_comb begin
    state_d = state_q;
    cpuEn_d = 1'b0;

    unique case (state_q)
      HALTED: begin
        if (bus.halt_req) begin
          state_d = FAULT_HALT;
        end else if (bus.run) begin
          state_d = RUNNING;
        end else if (stepPress_q) begin
          state_d = STEP_ARMED;
        end
      end

      RUNNING: begin
        if (bus.halt_req) begin
          state_d = FAULT_HALT;
        end else if (!bus.run) begin
          state_d = HALTED;
        end
        cpuEn_d = tick & ~bus.halt_req & bus.run;
      end

      STEP_ARMED: begin
        if (bus.halt_req) begin
          state_d = FAULT_HALT;
        end else if (tick) begin
          state_d = HALTED;
        end
        cpuEn_d = tick & ~bus.halt_req;
      end

      FAULT_HALT: begin
        if (!bus.halt_req && !bus.run) begin
          state_d = HALTED;
        end
      end

      default: begin
        state_d = HALTED;
      end
    endcase

    running_d = (state_d == RUNNING);
    halted_d  = (state_d == FAULT_HALT);
  end

  // The pulse counter advances in the cycle after each enable pulse and
  // wraps silently at its width.
  always_comb begin
    enableCount_d = enableCount_q + COUNT_WIDTH'(cpuEn_q);
  end

  // State register and registered outputs. The status flags are decoded
  // from the next state so they line up with the state register itself.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HALTED;
      cpuEn_q       <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      enableCount_q <= '0;
    end else begin
      state_q       <= state_d;
      cpuEn_q       <= cpuEn_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
      enableCount_q <= enableCount_d;
    end
  end

  assign bus.cpu_en       = cpuEn_q;
  assign bus.running      = running_q;
  assign bus.halted       = halted_q;
  assign bus.enable_count = enableCount_q;

endmodule

// File: tb/tb_clock_control.sv
// -----------------------------------------------------------------------------
// tb_clock_control
//
// Self-checking bench for clock_control built with a 4-bit pulse counter so
// that counter wrap-around is reachable quickly. A table of per-cycle
// vectors covers free-run, halt and mode changes; hand-written sequences
// cover debounce, single-step, counter wrap and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_clock_control;

  localparam int CW = 4;

  typedef struct packed {
    logic          div;
    logic          run;
    logic          halt;
    logic          en;
    logic          running;
    logic          halted;
    logic [CW-1:0] count;
  } vec_t;

  typedef struct {
    int            idx;
    logic          en;
    logic          running;
    logic          halted;
    logic [CW-1:0] count;
  } exp_t;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;
  vec_t vecs[$];
  exp_t sb[$];

  clock_control_if #(.COUNT_WIDTH(CW)) bus ();

  clock_control #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // Free-running system clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic div, input logic run, input logic halt,
                              input logic en, input logic running, input logic halted,
                              input int count);
    vec_t v;
    v.div     = div;
    v.run     = run;
    v.halt    = halt;
    v.en      = en;
    v.running = running;
    v.halted  = halted;
    v.count   = CW'(count);
    return v;
  endfunction

  task automatic applyStimulus(input logic div, input logic run, input logic halt,
                               input logic step);
    bus.clock_div = div;
    bus.run       = run;
    bus.halt_req  = halt;
    bus.step_btn  = step;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pops one scoreboard entry and compares it against the current outputs.
  task automatic drainOne();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput($sformatf("vec%0d_cpu_en", e.idx), int'(bus.cpu_en), int'(e.en));
    checkOutput($sformatf("vec%0d_running", e.idx), int'(bus.running), int'(e.running));
    checkOutput($sformatf("vec%0d_halted", e.idx), int'(bus.halted), int'(e.halted));
    checkOutput($sformatf("vec%0d_count", e.idx), int'(bus.enable_count), int'(e.count));
  endtask

  // Runs n clocks with the inputs as currently driven, counting the cycles
  // in which cpu_en was high. Ends on a falling edge.
  task automatic runCycles(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clock);
      if (bus.cpu_en) pulses++;
    end
  endtask

  // One divider period: high for one clock, low for three.
  task automatic tickOnce(output int pulses);
    int p1;
    int p2;
    bus.clock_div = 1'b1;
    runCycles(1, p1);
    bus.clock_div = 1'b0;
    runCycles(3, p2);
    pulses = p1 + p2;
  endtask

  initial begin
    int p;
    int total;

    errors = 0;
    checks = 0;

    // Per-cycle vectors {div, run, halt} -> outputs after the next edge.
    // Six divider periods (high 2, low 2) in free-run: the first tick lands
    // while still HALTED, each later tick gives one pulse, the count
    // follows one cycle behind.
    for (int per = 0; per < 6; per++) begin
      vecs.push_back(mk(1, 1, 0, (per > 0), 1, 0, (per > 0) ? per - 1 : 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, per));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, per));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, per));
    end
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 5));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5));

    // Reset values.
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (2) @(negedge clock);
    checkOutput("reset_cpu_en", int'(bus.cpu_en), 0);
    checkOutput("reset_running", int'(bus.running), 0);
    checkOutput("reset_halted", int'(bus.halted), 0);
    checkOutput("reset_count", int'(bus.enable_count), 0);
    reset_n = 1'b1;

    // Table-driven part with scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clock);
      drainOne();
      applyStimulus(vecs[i].div, vecs[i].run, vecs[i].halt, 1'b0);
      e.idx     = i;
      e.en      = vecs[i].en;
      e.running = vecs[i].running;
      e.halted  = vecs[i].halted;
      e.count   = vecs[i].count;
      sb.push_back(e);
    end
    @(negedge clock);
    drainOne();

    // Bouncing step button: 1-0-1-0 at one-cycle spacing must not arm.
    applyStimulus(0, 0, 0, 1);
    runCycles(1, p);
    bus.step_btn = 1'b0;
    runCycles(1, p);
    bus.step_btn = 1'b1;
    runCycles(1, p);
    bus.step_btn = 1'b0;
    runCycles(8, p);
    tickOnce(p);
    checkOutput("bounce_no_pulse", p, 0);

    // Held press: exactly one pulse on the next tick, then back to HALTED.
    bus.step_btn = 1'b1;
    runCycles(10, p);
    checkOutput("armed_waits_for_tick", p, 0);
    bus.step_btn = 1'b0;
    tickOnce(p);
    checkOutput("step_one_pulse", p, 1);
    checkOutput("step_count", int'(bus.enable_count), 6);
    checkOutput("step_running", int'(bus.running), 0);
    checkOutput("step_halted", int'(bus.halted), 0);
    runCycles(10, p);
    tickOnce(p);
    checkOutput("step_release_no_pulse", p, 0);

    // Halt coincident with the tick while armed: no pulse, fault halt.
    bus.step_btn = 1'b1;
    runCycles(8, p);
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b1;
    tickOnce(p);
    checkOutput("armed_halt_no_pulse", p, 0);
    checkOutput("armed_halt_halted", int'(bus.halted), 1);
    bus.halt_req = 1'b0;
    runCycles(2, p);
    tickOnce(p);
    checkOutput("armed_halt_cancels_step", p, 0);
    checkOutput("armed_halt_exit", int'(bus.halted), 0);

    // Asynchronous reset from fault halt clears outputs before the next edge.
    bus.halt_req = 1'b1;
    runCycles(1, p);
    checkOutput("fault_halted", int'(bus.halted), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_halted", int'(bus.halted), 0);
    checkOutput("async_reset_count6", int'(bus.enable_count), 0);

    // Divider already high at reset release: its tick is taken in the first
    // clock while still HALTED, so no pulse while it stays high.
    @(negedge clock);
    applyStimulus(1, 1, 0, 0);
    reset_n = 1'b1;
    runCycles(3, p);
    checkOutput("div_high_release_no_pulse", p, 0);
    checkOutput("div_high_release_running", int'(bus.running), 1);
    bus.clock_div = 1'b0;
    runCycles(1, p);

    // Counter wrap with a 4-bit counter over 17 ticks.
    total = 0;
    for (int k = 1; k <= 17; k++) begin
      tickOnce(p);
      total += p;
      if (k == 15) checkOutput("wrap_count15", int'(bus.enable_count), 15);
      if (k == 16) checkOutput("wrap_count16", int'(bus.enable_count), 0);
      if (k == 17) checkOutput("wrap_count17", int'(bus.enable_count), 1);
    end
    checkOutput("wrap_total_pulses", total, 17);

    // Asynchronous reset while armed: outputs clear mid-cycle and the armed
    // step is lost.
    bus.run = 1'b0;
    runCycles(2, p);
    bus.step_btn = 1'b1;
    runCycles(8, p);
    #2;
    reset_n = 1'b0;
    bus.step_btn = 1'b0;
    #1;
    checkOutput("armed_reset_cpu_en", int'(bus.cpu_en), 0);
    checkOutput("armed_reset_running", int'(bus.running), 0);
    checkOutput("armed_reset_halted", int'(bus.halted), 0);
    checkOutput("armed_reset_count", int'(bus.enable_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    runCycles(10, p);
    total = p;
    tickOnce(p);
    checkOutput("armed_reset_no_pulse", total + p, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
